combination_sender: RTL and testbench



---
 rtl/combination_sender_pkg.sv | 24 ++
 rtl/combination_sender.sv | 162 ++++++++++++++++
 tb/tb_combination_sender.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/combination_sender_pkg.sv
// Shared definitions for the combination-lock code transmitter.
// Holds the FSM state encoding, single-bit level constants and the
// length clamp helper used when a transmission request is accepted.
package combination_sender_pkg;

    // FSM state encoding; values are fixed so waveforms read the same
    // across builds and tools.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_GAP   = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;

    // Limits a requested bit count to the largest code the sender can hold.
    function automatic int clamp_len(input int req_len, input int max_len);
        return (req_len > max_len) ? max_len : req_len;
    endfunction

endpackage

// File: rtl/combination_sender.sv
// Serial key/update transmitter for the combination lock: sends a latched
// code MSB-first, one bit per update strobe, with GAP idle cycles between
// strobes, then samples the lock's unlock output and reports success.
//
// Ports:
//   clk      - system clock, all state on its rising edge
//   reset    - synchronous, active-high reset (highest priority)
//   start    - transmit request, honoured only while idle
//   code     - code word; bit len-1 goes out first, bit 0 last
//   len      - number of bits to send, clamped to MAX_LEN
//   unlock   - unlock feedback from the lock
//   key      - key bit, valid while update is high
//   update   - one-cycle strobe consumed by the lock
//   busy     - high from the cycle after acceptance up to (not incl.) done
//   done     - one-cycle completion pulse
//   success  - unlock sample, valid from done until the next acceptance
//
// All outputs are registered: each state branch loads the output registers
// with the values that belong to the state being entered, so the outputs
// line up with the state register without any input-to-output path.
module combination_sender
    import combination_sender_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int GAP     = 2,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] code,
    input  logic [LEN_W-1:0]   len,
    input  logic               unlock,
    output logic               key,
    output logic               update,
    output logic               busy,
    output logic               done,
    output logic               success
);

    localparam int GAP_W = 4;

    state_t             r_state;
    logic [MAX_LEN-1:0] r_code;
    logic [LEN_W-1:0]   r_idx;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_key;
    logic               r_update;
    logic               r_busy;
    logic               r_done;
    logic               r_success;

    logic [LEN_W-1:0]   w_len_c;
    logic [LEN_W-1:0]   w_len_m1;
    logic [LEN_W-1:0]   w_idx_m1;
    logic [MAX_LEN-1:0] w_sh_first;
    logic [MAX_LEN-1:0] w_sh_cur;
    logic [MAX_LEN-1:0] w_sh_next;

    assign w_len_c  = LEN_W'(clamp_len(int'(len), MAX_LEN));
    assign w_len_m1 = w_len_c - LEN_W'(1);
    assign w_idx_m1 = r_idx - LEN_W'(1);

    // Bit selects done by shifting so the index width never has to match
    // the code width exactly.
    assign w_sh_first = code >> w_len_m1;     // first bit, straight from the port
    assign w_sh_cur   = r_code >> r_idx;      // bit at the current index
    assign w_sh_next  = r_code >> w_idx_m1;   // bit for back-to-back sends

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_code    <= '0;
            r_idx     <= '0;
            r_gap_cnt <= '0;
            r_key     <= LOW;
            r_update  <= LOW;
            r_busy    <= LOW;
            r_done    <= LOW;
            r_success <= LOW;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_done   <= LOW;
                    r_update <= LOW;
                    if (start) begin
                        r_code    <= code;
                        r_busy    <= HIGH;
                        r_success <= LOW;
                        if (w_len_c != '0) begin
                            r_idx    <= w_len_m1;
                            r_key    <= w_sh_first[0];
                            r_update <= HIGH;
                            r_state  <= ST_SEND;
                        end else begin
                            r_state  <= ST_CHECK;
                        end
                    end
                end

                ST_SEND: begin
                    // Leave for CHECK at index 0 so the index never wraps.
                    if (r_idx == '0) begin
                        r_update <= LOW;
                        r_state  <= ST_CHECK;
                    end else begin
                        r_idx <= w_idx_m1;
                        if (GAP > 0) begin
                            r_update  <= LOW;
                            r_gap_cnt <= GAP_W'(GAP - 1);
                            r_state   <= ST_GAP;
                        end else begin
                            r_update <= HIGH;
                            r_key    <= w_sh_next[0];
                            r_state  <= ST_SEND;
                        end
                    end
                end

                ST_GAP: begin
                    // key keeps the previous bit while update is low.
                    if (r_gap_cnt == '0) begin
                        r_update <= HIGH;
                        r_key    <= w_sh_cur[0];
                        r_state  <= ST_SEND;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end

                ST_CHECK: begin
                    // The lock absorbed the final bit on the last SEND edge,
                    // so unlock is already settled here.
                    r_success <= unlock;
                    r_busy    <= LOW;
                    r_done    <= HIGH;
                    r_state   <= ST_DONE;
                end

                ST_DONE: begin
                    // start is deliberately not looked at in this state.
                    r_done  <= LOW;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_update <= LOW;
                    r_busy   <= LOW;
                    r_done   <= LOW;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign key     = r_key;
    assign update  = r_update;
    assign busy    = r_busy;
    assign done    = r_done;
    assign success = r_success;

endmodule

// File: tb/tb_combination_sender.sv
module tb_combination_sender;

    localparam logic [4:0] LOCK_CODE = 5'b01011;

    logic       clk;
    logic       reset;
    logic [1:0] start;
    logic [7:0] code;
    logic [3:0] len;
    logic [1:0] unlock, key, update, busy, done, success;
    logic [4:0] lk_sh [2];

    int    checks   = 0;
    int    failures = 0;
    string scen     = "reset";

    bit hist0[$];
    bit hist1[$];

    // Instance 0: GAP=2; instance 1: GAP=0. code/len/reset are shared,
    // start is per instance.
    combination_sender #(.MAX_LEN(8), .GAP(2)) u_g2 (
        .clk(clk), .reset(reset), .start(start[0]), .code(code), .len(len),
        .unlock(unlock[0]), .key(key[0]), .update(update[0]), .busy(busy[0]),
        .done(done[0]), .success(success[0])
    );

    combination_sender #(.MAX_LEN(8), .GAP(0)) u_g0 (
        .clk(clk), .reset(reset), .start(start[1]), .code(code), .len(len),
        .unlock(unlock[1]), .key(key[1]), .update(update[1]), .busy(busy[1]),
        .done(done[1]), .success(success[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple combination lock: remembers the last five keys it received and
    // opens when they equal LOCK_CODE.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset)          lk_sh[i] <= '0;
            else if (update[i]) lk_sh[i] <= {lk_sh[i][3:0], key[i]};
        end
    end
    assign unlock[0] = (lk_sh[0] == LOCK_CODE);
    assign unlock[1] = (lk_sh[1] == LOCK_CODE);

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=%b expected=%b t=%0t", scen, tag, obs, exp, $time);
        end
    endtask

    // Lock outcome from the full list of bits delivered since reset.
    function automatic logic exp_success(input int s);
        bit   q[$];
        logic [4:0] last5;
        int   j;
        if (s == 0) q = hist0; else q = hist1;
        for (int i = 0; i < 5; i++) begin
            j = q.size() - 5 + i;
            last5[4-i] = (j >= 0) ? q[j] : 1'b0;
        end
        return last5 == LOCK_CODE;
    endfunction

    task automatic clear_hist();
        hist0.delete();
        hist1.delete();
    endtask

    // One transmission on instance s. rs1/rs2: cycles with a stray start;
    // rst_at: cycle after which reset is pulsed (-1 = none).
    task automatic run_txn(input int s, input logic [7:0] c, input int l,
                           input int rs1, input int rs2, input int rst_at);
        int   g, lc, last_pulse, done_cyc, k;
        logic e_upd, e_succ;
        g          = (s == 0) ? 2 : 0;
        lc         = (l > 8) ? 8 : l;
        last_pulse = (lc == 0) ? 0 : 1 + (lc - 1) * (1 + g);
        done_cyc   = (lc == 0) ? 2 : last_pulse + 2;
        for (int b = lc - 1; b >= 0; b--) begin
            if (s == 0) hist0.push_back(c[b]); else hist1.push_back(c[b]);
        end
        e_succ = exp_success(s);

        @(negedge clk);
        code     = c;
        len      = 4'(l);
        start[s] = 1'b1;
        @(posedge clk);                 // acceptance edge = cycle 0
        #1;
        start[s] = 1'b0;
        code     = 8'($urandom);        // must not disturb the transmission
        len      = 4'($urandom);
        for (int t = 1; t <= done_cyc + 1; t++) begin
            @(negedge clk);
            k     = (t - 1) / (1 + g);
            e_upd = (lc > 0) && (t <= last_pulse) && ((t - 1) % (1 + g) == 0);
            chk("update", update[s], e_upd);
            if (e_upd) chk("key", key[s], c[lc - 1 - k]);
            chk("busy", busy[s], t < done_cyc);
            chk("done", done[s], t == done_cyc);
            chk("success", success[s], (t >= done_cyc) ? e_succ : 1'b0);
            start[s] = (t == rs1) || (t == rs2);
            if (t == rst_at) begin
                start[s] = 1'b0;
                reset    = 1'b1;
                @(negedge clk);
                chk("rst_update", update[s], 1'b0);
                chk("rst_busy", busy[s], 1'b0);
                chk("rst_done", done[s], 1'b0);
                chk("rst_success", success[s], 1'b0);
                chk("rst_key", key[s], 1'b0);
                reset = 1'b0;
                clear_hist();
                return;
            end
        end
        start[s] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_hist();
    endtask

    initial begin
        int   rs, rl;
        logic [7:0] rc;
        reset = 1'b1;
        start = '0;
        code  = '0;
        len   = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_key", key[i], 1'b0);
            chk("rst_update", update[i], 1'b0);
            chk("rst_busy", busy[i], 1'b0);
            chk("rst_done", done[i], 1'b0);
            chk("rst_success", success[i], 1'b0);
        end
        reset = 1'b0;
        clear_hist();

        scen = "s1_open";     run_txn(0, 8'b00001011, 5, -1, -1, -1);
        scen = "s2_wrong";    run_txn(0, 8'b00001010, 5, -1, -1, -1);
        scen = "s3_restarts"; run_txn(0, 8'b00001011, 5, 3, 15, -1);
        scen = "s4_midreset"; run_txn(0, 8'b00001011, 5, -1, -1, 5);
        scen = "s4_fresh";    run_txn(0, 8'b00001011, 5, -1, -1, -1);
        do_reset();
        scen = "s5_len0";     run_txn(0, 8'hFF, 0, -1, -1, -1);
        scen = "s6_clamp";    run_txn(1, 8'hA5, 9, -1, -1, -1);
        scen = "len0_g0";     run_txn(1, 8'h3C, 0, -1, -1, -1);

        scen = "random";
        for (int n = 0; n < 16; n++) begin
            rs = $urandom_range(0, 1);
            rl = $urandom_range(0, 9);
            rc = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rc = 8'h0B;
                rl = 5;
            end
            run_txn(rs, rc, rl, -1, -1, -1);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
